// File: rtl/mem_wr.sv
`default_nettype none
// ============================================================================
// Module   : mem_wr
// Purpose  : Frame-buffer write side. Captures one pixel frame into the frame
//            BRAM at sequential addresses, then raises a REQ_LEN-cycle request
//            pulse that starts the downstream BRAM-to-FIFO read stage.
// Options  : MEM_WR_STATS_EN adds saturating frame and drop counters
//            (o_frame_cnt, o_drop_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module mem_wr #(
  parameter int BRAM_DEPTH = 16384,
  parameter int DATA_WIDTH = 12,
  // Must be >= 3 so a reader that double-flops o_req still sees the pulse.
  parameter int REQ_LEN    = 4,
  // A single-location frame still needs a one-bit address port.
  localparam int AW = (BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_en,
  input  logic                  i_sof,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_wr,
  output logic [AW-1:0]         o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_req,
  output logic                  o_busy
`ifdef MEM_WR_STATS_EN
  ,
  output logic [15:0]           o_frame_cnt,
  output logic [15:0]           o_drop_cnt
`endif
);

  // Request counter must be able to hold the value REQ_LEN itself.
  localparam int            RCW       = $clog2(REQ_LEN + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);
  localparam logic [RCW-1:0] REQ_DONE = RCW'(REQ_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_REQ   = 2'd2
  } state_t;

  state_t         state;
  logic [AW-1:0]  wptr;
  logic [RCW-1:0] req_cnt;

  logic           take;
  logic [AW-1:0]  addr_now;
  logic           last;

  // Decide whether this cycle's pixel is written, and where it lands.
  always_comb begin
    take     = 1'b0;
    addr_now = wptr;
    last     = 1'b0;
    // A sof pixel always restarts the frame at address 0, both when a new
    // frame begins in IDLE and when it aborts a partial frame in WRITE.
    if (i_sof) begin
      addr_now = '0;
    end
    case (state)
      ST_IDLE:  take = i_valid & i_sof & i_en;
      ST_WRITE: take = i_valid;
      default:  take = 1'b0;
    endcase
    last = (addr_now == LAST_ADDR);
  end

  // Frame capture / request FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state   <= ST_IDLE;
      wptr    <= '0;
      req_cnt <= '0;
      o_wr    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
      o_req   <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_wr <= 1'b0;
      case (state)
        ST_IDLE, ST_WRITE: begin
          o_req <= 1'b0;
          if (take) begin
            o_wr    <= 1'b1;
            o_waddr <= addr_now;
            o_wdata <= i_data;
            o_busy  <= 1'b1;
            if (last) begin
              // Wrap the pointer so no out-of-range address is ever held.
              wptr    <= '0;
              req_cnt <= '0;
              state   <= ST_REQ;
            end else begin
              wptr  <= addr_now + AW'(1);
              state <= ST_WRITE;
            end
          end
        end
        ST_REQ: begin
          // Every pixel is dropped here; the pulse cannot be re-triggered.
          if (req_cnt == REQ_DONE) begin
            o_req   <= 1'b0;
            o_busy  <= 1'b0;
            req_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            o_req   <= 1'b1;
            req_cnt <= req_cnt + RCW'(1);
          end
        end
        default: begin
          o_req   <= 1'b0;
          o_busy  <= 1'b0;
          req_cnt <= '0;
          wptr    <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_WR_STATS_EN
  logic frame_evt;
  logic drop_evt;

  // Classify this cycle for the statistics counters.
  always_comb begin
    frame_evt = take & last;
    drop_evt  = 1'b0;
    if (i_valid & i_sof) begin
      case (state)
        ST_IDLE:  drop_evt = ~i_en;   // ignored sof while disarmed
        ST_WRITE: drop_evt = 1'b1;    // mid-frame abort
        ST_REQ:   drop_evt = 1'b1;    // frame skipped during request
        default:  drop_evt = 1'b0;
      endcase
    end
  end

  // Saturating frame / drop counters.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_frame_cnt <= '0;
      o_drop_cnt  <= '0;
    end else begin
      if (frame_evt && (o_frame_cnt != 16'hFFFF)) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
      if (drop_evt && (o_drop_cnt != 16'hFFFF)) begin
        o_drop_cnt <= o_drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
